// File: rtl/seq_divider_8by4_pkg.sv
// seq_divider_8by4_pkg: shared state encoding and default widths for the sequential divider
package seq_divider_8by4_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    // Sized wide so any DW up to 64 can take its all-ones value with a width cast.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/seq_divider_8by4_if.sv
// seq_divider_8by4_if: start/busy/done handshake plus operand and result buses
//   start, dividend, divisor : requester -> divider
//   busy, done, quotient, remainder, div_by_zero : divider -> requester
interface seq_divider_8by4_if
    import seq_divider_8by4_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) ();

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_8by4_div_step.sv
// seq_divider_8by4_div_step: one restoring-division step, resolving a single quotient bit
//   rem      in  VW+1  partial remainder so far
//   bit_in   in  1     next dividend bit, MSB first
//   divisor  in  VW    divisor
//   rem_next out VW+1  partial remainder after this step
//   q_bit    out 1     quotient bit produced by this step
module seq_divider_8by4_div_step
    import seq_divider_8by4_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   rem,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_next,
    output logic          q_bit
);

    // The compare uses the full shifted value; since rem < divisor on entry the
    // top bit is always zero, so both truncations below are lossless.
    assign q_bit    = {rem, bit_in} >= {2'b00, divisor};
    assign rem_next = q_bit ? (VW+1)'({rem, bit_in} - {2'b00, divisor}) : (VW+1)'({rem, bit_in});

endmodule

// File: rtl/seq_divider_8by4.sv
// seq_divider_8by4: sequential restoring divider, one quotient bit per clock
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport: start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
module seq_divider_8by4
    import seq_divider_8by4_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_divider_8by4_if.slave   bus
);

    localparam int CW = $clog2(DW);

    state_t        state;
    logic [DW-1:0] dividend_sr;
    logic [DW-2:0] quot_sr;
    logic [VW-1:0] divisor_r;
    logic [VW:0]   rem_r;
    logic [VW:0]   rem_next;
    logic          q_bit;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    seq_divider_8by4_div_step #(.VW(VW)) u_step (
        .rem      (rem_r),
        .bit_in   (dividend_sr[DW-1]),
        .divisor  (divisor_r),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dividend_sr <= '0;
            quot_sr     <= '0;
            divisor_r   <= '0;
            rem_r       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.divisor == '0) begin
                        state <= DONE;
                    end else if (bus.start) begin
                        state       <= RUN;
                        dividend_sr <= bus.dividend;
                        divisor_r   <= bus.divisor;
                        rem_r       <= '0;
                        quot_sr     <= '0;
                        cnt         <= CW'(DW - 1);
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    rem_r       <= rem_next;
                    quot_sr     <= {quot_sr[DW-3:0], q_bit};
                    dividend_sr <= dividend_sr << 1;
                    cnt         <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= {quot_sr, q_bit};
                        remainder   <= rem_next[VW-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    // Arriving from RUN, done is already up and this is the pulse cycle.
                    // Arriving from a divide-by-zero accept, done is still low: raise it
                    // now with the fixed result and leave on the following edge.
                    if (!done) begin
                        done        <= 1'b1;
                        quotient    <= DW'(DIV0_QUOTIENT);
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;

endmodule

// File: doc/seq_divider_8by4.md
# seq_divider_8by4

Sequential restoring divider, the inverse of the team's 4x4 array multiplier: splits an 8-bit product-width dividend by a 4-bit divisor into an 8-bit quotient and 4-bit remainder. It resolves one quotient bit per clock under a start/busy/done handshake. It sits beside the multiplier in the arithmetic tile so a multiply result can be fed straight back for checking.

## Interface
Parameters:
- DW, 8, dividend/quotient width
- VW, 4, divisor/remainder width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- dividend  in  DW  sampled on the accepting edge
- divisor  in  VW  sampled on the accepting edge
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; results valid
- quotient  out  DW  result, held until next accepted start
- remainder  out  VW  result, held until next accepted start
- div_by_zero  out  1  flag for last operation, held like quotient

## Operation
- States:
  - IDLE: accept on start=1.
  - RUN: DW iterations.
  - DONE: one cycle, then IDLE unconditionally.
- Accept in IDLE with divisor≠0:
  - load dividend shift register and divisor register
  - clear partial remainder (VW+1 bits) and quotient shift register
  - set iteration counter to DW-1; go to RUN
- Each RUN cycle, MSB first:
  - r' = {r[VW-1:0], dividend_sr MSB}
  - if r' ≥ divisor: r = r' − divisor and shift 1 into quotient; else r = r' and shift 0
  - shift dividend_sr left
  - at counter 0, go to DONE and register quotient, remainder and div_by_zero=0
- Accept in IDLE with divisor=0:
  - go straight to DONE
  - quotient = all ones, remainder = 0, div_by_zero = 1
- Arithmetic:
  - unsigned only
  - remainder < divisor always holds, so the VW+1 bit partial remainder never overflows
  - dividend = quotient·divisor + remainder
- start is ignored in RUN and DONE, including a start asserted during the done cycle. No queuing.
- dividend and divisor may change freely after the accepting edge.

## Timing
- Reset (async assert, sync-released by the tile):
  - state IDLE
  - busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0
  - internal registers 0
- Accepting edge T:
  - busy=1 from T through edge T+DW
  - done=1 from edge T+DW to T+DW+1 (exactly one cycle)
  - quotient/remainder/div_by_zero update on edge T+DW
  - latency is DW cycles to done (8 by default); throughput is one op per DW+2 cycles minimum
- Divide-by-zero: busy stays 0; done=1 for one cycle starting at edge T+1.
- busy and done are never high together.
- Outputs are glitch-free registers. No combinational path from inputs to outputs.
- Reset mid-RUN: immediate abort to IDLE with all outputs at reset values. No done pulse is emitted for the aborted op.

## Structure
- Shared package holds:
  - state enum {IDLE, RUN, DONE}, 2 bits
  - default DW/VW constants
  - DIV0_QUOTIENT constant (all ones)
- One combinational sub-module `div_step`: inputs partial remainder, next dividend bit and divisor; outputs next remainder and quotient bit. It is instantiated once and reused each cycle.
- The top holds the FSM, counter ($clog2(DW) bits) and registers.

## Test plan
- start, 143/13 → done at T+8: quotient=11, remainder=0, div_by_zero=0; busy high exactly 8 cycles.
- Back-to-back ops 200/7 then 255/1 → 28 r4, then 255 r0. The second start, asserted during the first op's done cycle, is ignored until IDLE; accepting it on the following edge yields correct results.
- 37/0 → done at T+1, quotient=255, remainder=0, div_by_zero=1, busy never high. A following 15/15 → 1 r0 with div_by_zero=0.
- start pulsed repeatedly and dividend/divisor changed during RUN of 225/15 → result still 15 r0. Exactly one done pulse.
- rst_n asserted at T+4 of 100/3 → all outputs 0 immediately, no done. After release, 100/3 → 33 r1.
- Random sweep of all 256×15 nonzero pairs: dividend == quotient·divisor + remainder and remainder < divisor for every pair.
